// File: rtl/spi_slave_rx_pkg.sv
// Shared constants and types for the SPI slave receiver.
//  SPI_WORD_W       default word width (MSB first)
//  SPI_SYNC_STAGES  default synchronizer depth per pin
//  SPI_CPOL/CPHA    the only supported mode (mode 0)
//  spi_state_e      receiver FSM states
package spi_slave_rx_pkg;

   localparam int unsigned SPI_WORD_W      = 16;
   localparam int unsigned SPI_SYNC_STAGES = 2;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   typedef enum logic {
      StIdle,
      StActive
   } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the received-word valid/ready port of spi_slave_rx.
//  spi_clk/spi_cs/spi_mosi  pins from the SPI master (async to clk)
//  spi_miso                 serial response to the master
//  rx_data/rx_valid/rx_ready received-word handshake
//  tx_data                  response word, sampled at each word start
//  rx_overrun/frame_err     single-cycle error pulses
// Modport slave is the receiver's view, master is the environment's view.
interface spi_slave_rx_if
   import spi_slave_rx_pkg::*;
#(
   parameter int unsigned WORD_W = SPI_WORD_W
);

   logic              spi_clk;
   logic              spi_cs;
   logic              spi_mosi;
   logic              spi_miso;
   logic [WORD_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [WORD_W-1:0] tx_data;
   logic              rx_overrun;
   logic              frame_err;

   modport slave (
      input  spi_clk, spi_cs, spi_mosi, rx_ready, tx_data,
      output spi_miso, rx_data, rx_valid, rx_overrun, frame_err
   );

   modport master (
      output spi_clk, spi_cs, spi_mosi, rx_ready, tx_data,
      input  spi_miso, rx_data, rx_valid, rx_overrun, frame_err
   );

endinterface

// File: rtl/spi_slave_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
//  clk    system clock
//  reset  synchronous active-high reset; all stages load IDLE_VAL
//  i_d    asynchronous input
//  o_q    synchronized output (last stage)
module spi_slave_rx_sync #(
   parameter int unsigned STAGES   = 2,
   parameter logic        IDLE_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {STAGES{IDLE_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver. Oversamples SCLK/CS/MOSI on clk, assembles MSB-first words and
// offers them on a valid/ready port; shifts a response word out on MISO.
//  clk     system clock (>= 4x SCLK)
//  reset   synchronous active-high reset
//  io_bus  spi_slave_rx_if.slave: SPI pins, rx word handshake, tx word, error pulses
module spi_slave_rx
   import spi_slave_rx_pkg::*;
#(
   parameter int unsigned WORD_W      = SPI_WORD_W,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic           clk,
   input  logic           reset,
   spi_slave_rx_if.slave  io_bus
);

   localparam int unsigned     CNT_W    = $clog2(WORD_W) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

   logic w_sclk_s;
   logic w_cs_s;
   logic w_mosi_s;

   spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .i_d   (io_bus.spi_clk),
      .o_q   (w_sclk_s)
   );

   spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
      .clk   (clk),
      .reset (reset),
      .i_d   (io_bus.spi_cs),
      .o_q   (w_cs_s)
   );

   spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .i_d   (io_bus.spi_mosi),
      .o_q   (w_mosi_s)
   );

   // Delayed copies for edge detection, plus a fill-with-ones shift register that marks when the
   // synchronizers hold real pin values rather than their reset idle levels.
   logic                 r_sclk_d;
   logic                 r_cs_d;
   logic [SYNC_STAGES:0] r_settle;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sclk_d <= 1'b0;
         r_cs_d   <= 1'b1;
         r_settle <= '0;
      end else begin
         r_sclk_d <= w_sclk_s;
         r_cs_d   <= w_cs_s;
         r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      end
   end

   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_rise;
   logic w_cs_fall;

   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;
   // A CS held low through reset shows up as a 1->0 step once the synchronizer flushes its
   // idle value; masking until settled makes the slave wait for a genuine high-then-low.
   assign w_cs_fall   = ~w_cs_s & r_cs_d & r_settle[SYNC_STAGES];

   spi_state_e        r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_rx_shift;
   logic [WORD_W-1:0] r_tx_shift;
   logic [WORD_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_spi_miso;
   logic              r_rx_overrun;
   logic              r_frame_err;
   logic              w_word_done;

   // Counter sits at WORD_W for exactly one cycle after the last rising edge.
   assign w_word_done = (r_bit_cnt == CNT_FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_bit_cnt    <= '0;
         r_rx_shift   <= '0;
         r_tx_shift   <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_spi_miso   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
         if (r_rx_valid && io_bus.rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         unique case (r_state)
            StIdle: begin
               if (w_cs_fall) begin
                  r_state    <= StActive;
                  r_bit_cnt  <= '0;
                  r_tx_shift <= io_bus.tx_data;
                  r_spi_miso <= io_bus.tx_data[WORD_W-1];
               end
            end

            StActive: begin
               if (w_word_done) begin
                  // Loading here overrides the handshake clear above, keeping rx_valid high.
                  if (!r_rx_valid || io_bus.rx_ready) begin
                     r_rx_data  <= r_rx_shift;
                     r_rx_valid <= 1'b1;
                  end else begin
                     r_rx_overrun <= 1'b1;
                  end
                  r_bit_cnt  <= '0;
                  r_tx_shift <= io_bus.tx_data;
               end

               if (w_cs_rise) begin
                  r_state    <= StIdle;
                  r_bit_cnt  <= '0;
                  r_spi_miso <= 1'b0;
                  if (r_bit_cnt != '0 && !w_word_done) begin
                     r_frame_err <= 1'b1;
                  end
               end else if (!w_word_done) begin
                  if (w_sclk_rise) begin
                     r_rx_shift <= {r_rx_shift[WORD_W-2:0], w_mosi_s};
                     r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                  end
                  if (w_sclk_fall) begin
                     // The fall right after a word boundary presents the freshly loaded MSB
                     // instead of shifting past it.
                     if (r_bit_cnt == '0) begin
                        r_spi_miso <= r_tx_shift[WORD_W-1];
                     end else begin
                        r_tx_shift <= r_tx_shift << 1;
                        r_spi_miso <= r_tx_shift[WORD_W-2];
                     end
                  end
               end
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.spi_miso   = r_spi_miso;
   assign io_bus.rx_data    = r_rx_data;
   assign io_bus.rx_valid   = r_rx_valid;
   assign io_bus.rx_overrun = r_rx_overrun;
   assign io_bus.frame_err  = r_frame_err;

endmodule
